// File: rtl/vx_ifetch_rsp_queue.sv
// vx_ifetch_rsp_queue: fetch-response FIFO between I-cache and decode, with per-warp pending flags.
// Latency: 1 cycle push-to-head, no fall-through. Backpressure: in_ready_o drops only when full, never from out_ready_i.
// Optional VX_IFQ_PERF_EN adds full/stall cycle counters.
module vx_ifetch_rsp_queue #(
  parameter int CORE_ID     = 0,
  parameter int DEPTH       = 4,
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int UUID_BITS   = 44,
  parameter int NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [NW_BITS-1:0]     in_wid_i,
  input  logic [NUM_THREADS-1:0] in_tmask_i,
  input  logic [31:0]            in_pc_i,
  input  logic [31:0]            in_data_i,
  input  logic [UUID_BITS-1:0]   in_uuid_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [NW_BITS-1:0]     out_wid_o,
  output logic [NUM_THREADS-1:0] out_tmask_o,
  output logic [31:0]            out_pc_o,
  output logic [31:0]            out_data_o,
  output logic [UUID_BITS-1:0]   out_uuid_o,
  output logic [CNT_W-1:0]       count_o,
  output logic [NUM_WARPS-1:0]   warp_pending_o
`ifdef VX_IFQ_PERF_EN
  ,
  output logic [63:0]            perf_full_cycles_o,
  output logic [63:0]            perf_stall_cycles_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [NW_BITS-1:0]     wid;
    logic [NUM_THREADS-1:0] tmask;
    logic [31:0]            pc;
    logic [31:0]            data;
    logic [UUID_BITS-1:0]   uuid;
  } entry_t;

  entry_t               r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic [CNT_W-1:0]     r_cnt [NUM_WARPS];
  logic                 w_push;
  logic                 w_pop;
  logic [NUM_WARPS-1:0] w_inc;
  logic [NUM_WARPS-1:0] w_dec;
  entry_t               w_head;

  assign in_ready_o  = (r_count != CNT_W'(DEPTH));
  assign out_valid_o = (r_count != '0);
  assign w_push      = in_valid_i & in_ready_o;
  assign w_pop       = out_valid_o & out_ready_i;
  assign count_o     = r_count;

  assign w_head      = r_mem[r_rd_ptr];
  assign out_wid_o   = w_head.wid;
  assign out_tmask_o = w_head.tmask;
  assign out_pc_o    = w_head.pc;
  assign out_data_o  = w_head.data;
  assign out_uuid_o  = w_head.uuid;

  // Payload storage needs no reset; out_valid_o qualifies it.
  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) begin
      r_mem[r_wr_ptr] <= {in_wid_i, in_tmask_i, in_pc_i, in_data_i, in_uuid_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      w_inc[w] = w_push && (in_wid_i == NW_BITS'(w));
      w_dec[w] = w_pop && (w_head.wid == NW_BITS'(w));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int w = 0; w < NUM_WARPS; w++) r_cnt[w] <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (flush_i)                     r_cnt[w] <= '0;
        else if (w_inc[w] && !w_dec[w])  r_cnt[w] <= r_cnt[w] + CNT_W'(1);
        else if (!w_inc[w] && w_dec[w])  r_cnt[w] <= r_cnt[w] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    warp_pending_o = '0;
    for (int w = 0; w < NUM_WARPS; w++) warp_pending_o[w] = (r_cnt[w] != '0);
  end

`ifdef VX_IFQ_PERF_EN
  // Perf counters survive flush; only reset clears them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_full_cycles_o  <= '0;
      perf_stall_cycles_o <= '0;
    end else begin
      if (in_valid_i && !in_ready_o)   perf_full_cycles_o  <= perf_full_cycles_o + 64'd1;
      if (out_valid_o && !out_ready_i) perf_stall_cycles_o <= perf_stall_cycles_o + 64'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  int w_sum;
  always_comb begin
    w_sum = 0;
    for (int w = 0; w < NUM_WARPS; w++) w_sum = w_sum + int'(r_cnt[w]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(w_push && r_count == CNT_W'(DEPTH)))
        else $error("ifq[%0d]: push while full", CORE_ID);
      assert (!(w_pop && r_count == '0))
        else $error("ifq[%0d]: pop while empty", CORE_ID);
      assert (w_sum == int'(r_count))
        else $error("ifq[%0d]: per-warp counters disagree with count", CORE_ID);
    end
  end
`endif

endmodule

// File: tb/tb_vx_ifetch_rsp_queue.sv
// Directed bench for vx_ifetch_rsp_queue (DEPTH=4, 4 warps); perf counters checked when VX_IFQ_PERF_EN is defined.
module tb_vx_ifetch_rsp_queue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_wid;
  logic [3:0]  in_tmask;
  logic [31:0] in_pc;
  logic [31:0] in_data;
  logic [43:0] in_uuid;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_wid;
  logic [3:0]  out_tmask;
  logic [31:0] out_pc;
  logic [31:0] out_data;
  logic [43:0] out_uuid;
  logic [2:0]  count;
  logic [3:0]  pending;
`ifdef VX_IFQ_PERF_EN
  logic [63:0] perf_full;
  logic [63:0] perf_stall;
`endif

  int tests = 0;
  int fails = 0;

  vx_ifetch_rsp_queue #(
    .CORE_ID(0), .DEPTH(4), .NUM_WARPS(4), .NUM_THREADS(4), .UUID_BITS(44)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_wid_i(in_wid), .in_tmask_i(in_tmask), .in_pc_i(in_pc),
    .in_data_i(in_data), .in_uuid_i(in_uuid),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_wid_o(out_wid), .out_tmask_o(out_tmask), .out_pc_o(out_pc),
    .out_data_o(out_data), .out_uuid_o(out_uuid),
    .count_o(count), .warp_pending_o(pending)
`ifdef VX_IFQ_PERF_EN
    , .perf_full_cycles_o(perf_full), .perf_stall_cycles_o(perf_stall)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic [1:0] wid, input logic [31:0] pc);
    in_valid = 1'b1;
    in_wid   = wid;
    in_tmask = 4'hF;
    in_pc    = pc;
    in_data  = pc ^ 32'h5A5A_0000;
    in_uuid  = {12'h0, pc};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tests++; if (pending !== 4'b0000) begin fails++; $display("FAIL reset_pending: got %b want 0000", pending); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_push();
    in_valid = 1'b1; in_wid = 2'd2; in_tmask = 4'b1011;
    in_pc = 32'h8000_0000; in_data = 32'h0000_0013; in_uuid = 44'h123;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_no_fallthrough: got %b want 0", out_valid); end
    step();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", out_valid); end
    tests++; if (out_wid !== 2'd2) begin fails++; $display("FAIL single_wid: got %0d want 2", out_wid); end
    tests++; if (out_pc !== 32'h8000_0000) begin fails++; $display("FAIL single_pc: got %h want 80000000", out_pc); end
    tests++; if (out_data !== 32'h0000_0013) begin fails++; $display("FAIL single_data: got %h want 00000013", out_data); end
    tests++; if (out_tmask !== 4'b1011) begin fails++; $display("FAIL single_tmask: got %b want 1011", out_tmask); end
    tests++; if (out_uuid !== 44'h123) begin fails++; $display("FAIL single_uuid: got %h want 123", out_uuid); end
    tests++; if (pending !== 4'b0100) begin fails++; $display("FAIL single_pending: got %b want 0100", pending); end
    tests++; if (count !== 3'd1) begin fails++; $display("FAIL single_count: got %0d want 1", count); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL single_pop_count: got %0d want 0", count); end
    tests++; if (pending !== 4'b0000) begin fails++; $display("FAIL single_pop_pending: got %b want 0000", pending); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      set_push(2'(i), 32'h1000 + 32'(4 * i));
      step();
    end
    set_push(2'd0, 32'h0000_DEAD);
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL full_count: got %0d want 4", count); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    step();
    step();
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL full_hold_count: got %0d want 4", count); end
    tests++; if (out_pc !== 32'h1000) begin fails++; $display("FAIL full_head_stable: got %h want 1000", out_pc); end
    out_ready = 1'b1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_no_writethrough: got %b want 0", in_ready); end
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    tests++; if (count !== 3'd3) begin fails++; $display("FAIL full_pop_count: got %0d want 3", count); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL full_pop_in_ready: got %b want 1", in_ready); end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tests++; if (out_pc !== 32'h1000 + 32'(4 * i)) begin fails++; $display("FAIL full_drain_pc%0d: got %h want %h", i, out_pc, 32'h1000 + 32'(4 * i)); end
      step();
    end
    out_ready = 1'b0;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL full_drain_count: got %0d want 0", count); end
  endtask

  task automatic test_order_pending();
    logic [1:0] ew [3];
    logic [3:0] ep [3];
    ew = '{2'd1, 2'd3, 2'd1};
    ep = '{4'b1010, 4'b1010, 4'b0010};
    for (int i = 0; i < 3; i++) begin
      set_push(ew[i], 32'h2000 + 32'(4 * i));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests++; if (out_wid !== ew[i]) begin fails++; $display("FAIL order_wid%0d: got %0d want %0d", i, out_wid, ew[i]); end
      tests++; if (pending !== ep[i]) begin fails++; $display("FAIL order_pending%0d: got %b want %b", i, pending, ep[i]); end
      step();
    end
    out_ready = 1'b0;
    tests++; if (pending !== 4'b0000) begin fails++; $display("FAIL order_pending_end: got %b want 0000", pending); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL order_valid_end: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    set_push(2'd0, 32'h3000); step();
    set_push(2'd0, 32'h3004); step();
    for (int i = 0; i < 6; i++) begin
      set_push(2'd0, 32'h3008 + 32'(4 * i));
      out_ready = 1'b1;
      tests++; if (out_pc !== 32'h3000 + 32'(4 * i)) begin fails++; $display("FAIL b2b_pc%0d: got %h want %h", i, out_pc, 32'h3000 + 32'(4 * i)); end
      step();
      tests++; if (count !== 3'd2) begin fails++; $display("FAIL b2b_count%0d: got %0d want 2", i, count); end
      tests++; if (pending !== 4'b0001) begin fails++; $display("FAIL b2b_pending%0d: got %b want 0001", i, pending); end
    end
    set_push(2'd2, 32'h4000);
    tests++; if (out_pc !== 32'h3018) begin fails++; $display("FAIL b2b_mixed_pc: got %h want 3018", out_pc); end
    step();
    in_valid = 1'b0;
    tests++; if (count !== 3'd2) begin fails++; $display("FAIL b2b_mixed_count: got %0d want 2", count); end
    tests++; if (pending !== 4'b0101) begin fails++; $display("FAIL b2b_mixed_pending: got %b want 0101", pending); end
    tests++; if (out_pc !== 32'h301C) begin fails++; $display("FAIL b2b_tail_pc0: got %h want 301c", out_pc); end
    step();
    tests++; if (out_pc !== 32'h4000 || out_wid !== 2'd2) begin fails++; $display("FAIL b2b_tail_pc1: got %h/%0d want 4000/2", out_pc, out_wid); end
    step();
    out_ready = 1'b0;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL b2b_drain_count: got %0d want 0", count); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      set_push(2'(i), 32'h6000 + 32'(4 * i));
      step();
    end
    set_push(2'd3, 32'hF1F1);
    flush = 1'b1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL flush_count: got %0d want 0", count); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    tests++; if (pending !== 4'b0000) begin fails++; $display("FAIL flush_pending: got %b want 0000", pending); end
    set_push(2'd1, 32'h5555);
    step();
    in_valid = 1'b0;
    tests++; if (out_pc !== 32'h5555) begin fails++; $display("FAIL flush_next_pc: got %h want 5555", out_pc); end
    tests++; if (count !== 3'd1) begin fails++; $display("FAIL flush_next_count: got %0d want 1", count); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_push(2'd3, 32'h7000); step();
    set_push(2'd3, 32'h7004); step();
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL rstmid_count: got %0d want 0", count); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
    tests++; if (pending !== 4'b0000) begin fails++; $display("FAIL rstmid_pending: got %b want 0000", pending); end
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

`ifdef VX_IFQ_PERF_EN
  task automatic test_perf();
    tests++; if (perf_full !== 64'd0 || perf_stall !== 64'd0) begin fails++; $display("FAIL perf_start: got %0d/%0d want 0/0", perf_full, perf_stall); end
    for (int i = 0; i < 4; i++) begin
      set_push(2'(i), 32'h9000 + 32'(4 * i));
      step();
    end
    repeat (5) step();
    in_valid = 1'b0;
    tests++; if (perf_full !== 64'd5) begin fails++; $display("FAIL perf_full: got %0d want 5", perf_full); end
    tests++; if (perf_stall !== 64'd8) begin fails++; $display("FAIL perf_stall: got %0d want 8", perf_stall); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    tests++; if (perf_full !== 64'd5) begin fails++; $display("FAIL perf_full_flush: got %0d want 5", perf_full); end
    tests++; if (perf_stall !== 64'd9) begin fails++; $display("FAIL perf_stall_flush: got %0d want 9", perf_stall); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (perf_full !== 64'd0 || perf_stall !== 64'd0) begin fails++; $display("FAIL perf_reset: got %0d/%0d want 0/0", perf_full, perf_stall); end
    step();
    rst_n = 1'b1;
    step();
  endtask
`endif

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_wid = '0; in_tmask = '0; in_pc = '0; in_data = '0; in_uuid = '0;
    test_reset();
    test_single_push();
    test_full();
    test_order_pending();
    test_back_to_back();
    test_flush();
    test_reset_mid();
`ifdef VX_IFQ_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
